// File: rtl/axis_decimator_pkg.sv
//------------------------------------------------------------------------------
// axis_decimator_pkg : shared types, widths and rate clamp for the decimator
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axis_decimator_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 16;
  localparam int DEFAULT_LOG2_MAX_RATE = 8;
  localparam int ACC_WIDTH             = DEFAULT_DATA_WIDTH + DEFAULT_LOG2_MAX_RATE;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

  function automatic logic [3:0] clamp_rate(input logic [3:0] rate,
                                            input logic [3:0] max_rate);
    return (rate > max_rate) ? max_rate : rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_output_reg.sv
//------------------------------------------------------------------------------
// axis_output_reg : one-deep AXI-Stream output register with upstream ready
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_output_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  s_axis_tready
);

  // A slot frees up in the same cycle the held sample drains.
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= load_data;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_averaging_decimator.sv
//------------------------------------------------------------------------------
// axis_averaging_decimator : boxcar average of 2^log2_rate samples per output
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_averaging_decimator
  import axis_decimator_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int LOG2_MAX_RATE = DEFAULT_LOG2_MAX_RATE
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [3:0]            log2_rate,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int ACC_W = DATA_WIDTH + LOG2_MAX_RATE;

  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   avg;
  logic [LOG2_MAX_RATE-1:0]  cnt;
  logic [LOG2_MAX_RATE:0]    block_len;
  logic [3:0]                rate_q;
  logic [3:0]                rate_next;
  logic                      accept;
  logic                      last;

  assign rate_next = clamp_rate(log2_rate, 4'(LOG2_MAX_RATE));
  assign block_len = (LOG2_MAX_RATE+1)'(1) << rate_q;
  assign last      = ({1'b0, cnt} == (block_len - 1'b1));
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign sum       = acc + {{LOG2_MAX_RATE{s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata};
  // Arithmetic shift floors toward -inf; the quotient always fits DATA_WIDTH.
  assign avg       = sum >>> rate_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc    <= '0;
      cnt    <= '0;
      rate_q <= '0;
    end else if (accept) begin
      if (last) begin
        acc    <= '0;
        cnt    <= '0;
        rate_q <= rate_next;
      end else begin
        acc    <= sum;
        cnt    <= cnt + 1'b1;
      end
    end else if (cnt == '0) begin
      // Between blocks the exponent tracks the input; mid-block it is frozen.
      rate_q <= rate_next;
    end
  end

  axis_output_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .load          (accept && last),
    .load_data     (avg[DATA_WIDTH-1:0]),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .s_axis_tready (s_axis_tready)
  );

endmodule

`default_nettype wire

// File: tb/tb_axis_averaging_decimator.sv
//------------------------------------------------------------------------------
// tb_axis_averaging_decimator : directed self-checking bench for the decimator
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_averaging_decimator;

  logic               aclk = 1'b0;
  logic               aresetn = 1'b0;
  logic [3:0]         log2_rate = 4'd0;
  logic signed [15:0] s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int out_q[$];
  int out_t[$];
  int in_t[$];

  always #5 aclk = ~aclk;

  axis_averaging_decimator #(
    .DATA_WIDTH    (16),
    .LOG2_MAX_RATE (8)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .log2_rate     (log2_rate),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready)
  );

  // Inputs change 1ns after posedge, so negedge sees the values the next edge uses.
  always @(negedge aclk) begin
    if (aresetn && s_valid && s_ready) in_t.push_back(cyc);
    if (aresetn && m_valid && m_ready) begin
      out_q.push_back(int'(m_data));
      out_t.push_back(cyc);
    end
    cyc++;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send(input int v);
    bit ok = 1'b0;
    s_data  = 16'(v);
    s_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge aclk);
      ok = s_ready;
      step(1);
    end
    s_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 50 && out_q.size() < n; i++) step(1);
    check("out_count", out_q.size(), n);
  endtask

  task automatic clear_q();
    out_q.delete();
    out_t.delete();
    in_t.delete();
  endtask

  initial begin
    int exp4[4];
    // reset state, sampled while reset is held
    step(2);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_s_ready", int'(s_ready), 1);
    aresetn = 1'b1;
    step(2);

    // pass-through at rate 0, one cycle latency, no gaps
    exp4 = '{14, -29, 7, 16};
    clear_q();
    for (int i = 0; i < 4; i++) send(exp4[i]);
    wait_out(4);
    for (int i = 0; i < 4 && i < out_q.size() && i < in_t.size(); i++) begin
      check("r0_data", out_q[i], exp4[i]);
      check("r0_latency", out_t[i] - in_t[i], 1);
    end

    // rate 2: positive average and floor toward -inf
    log2_rate = 4'd2;
    step(2);
    clear_q();
    send(14); send(-29); send(7); send(16);
    send(-1); send(-1); send(-1); send(-2);
    wait_out(2);
    if (out_q.size() == 2) begin
      check("r2_avg_pos", out_q[0], 2);
      check("r2_avg_floor", out_q[1], -2);
    end

    // rate 8 at both extremes of the sample range
    log2_rate = 4'd8;
    step(2);
    clear_q();
    for (int i = 0; i < 256; i++) send(-32768);
    for (int i = 0; i < 256; i++) send(32767);
    wait_out(2);
    if (out_q.size() == 2) begin
      check("r8_min", out_q[0], -32768);
      check("r8_max", out_q[1], 32767);
    end

    // out-of-range exponent clamps to 8: sum 0..255 = 32640, >>>8 = 127
    log2_rate = 4'd12;
    step(2);
    clear_q();
    for (int i = 0; i < 256; i++) send(i);
    wait_out(1);
    if (out_q.size() == 1) check("clamp_avg", out_q[0], 127);

    // backpressure at rate 1
    log2_rate = 4'd1;
    m_ready   = 1'b0;
    step(2);
    clear_q();
    send(10); send(20);
    step(3);
    check("stall_valid", int'(m_valid), 1);
    check("stall_s_ready", int'(s_ready), 0);
    check("stall_data", int'(m_data), 15);
    fork
      begin
        send(30); send(40); send(50); send(60);
      end
      begin
        step(4);
        check("stall_data_hold", int'(m_data), 15);
        m_ready = 1'b1;
      end
    join
    wait_out(3);
    if (out_q.size() == 3) begin
      check("stall_first", out_q[0], 15);
      check("stall_second", out_q[1], 35);
      check("stall_third", out_q[2], 55);
    end

    // rate change mid-block takes effect at the next block
    log2_rate = 4'd2;
    step(2);
    clear_q();
    send(1); send(3);
    log2_rate = 4'd0;
    send(5); send(7);
    send(9); send(-3);
    wait_out(3);
    if (out_q.size() == 3) begin
      check("rchg_block", out_q[0], 4);
      check("rchg_pass0", out_q[1], 9);
      check("rchg_pass1", out_q[2], -3);
    end

    // asynchronous reset mid-block drops the partial sum
    log2_rate = 4'd2;
    step(2);
    clear_q();
    send(100); send(100); send(100);
    #2 aresetn = 1'b0;
    #1;
    check("arst_valid", int'(m_valid), 0);
    check("arst_s_ready", int'(s_ready), 1);
    step(2);
    aresetn = 1'b1;
    step(2);
    send(4); send(4); send(8); send(8);
    wait_out(1);
    if (out_q.size() == 1) check("arst_new_block", out_q[0], 6);

    // asynchronous reset discards a pending output
    m_ready = 1'b0;
    clear_q();
    send(1); send(1); send(1); send(1);
    step(1);
    check("pend_valid", int'(m_valid), 1);
    #2 aresetn = 1'b0;
    #1;
    check("pend_cleared", int'(m_valid), 0);
    check("pend_data_zero", int'(m_data), 0);
    step(1);
    aresetn = 1'b1;
    m_ready = 1'b1;
    step(3);
    check("pend_no_output", out_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_averaging_decimator.md
# axis_averaging_decimator

Boxcar-averaging decimator on the 16-bit signed sample path, directly upstream of `signal_switch`, producing one of its two input signals. It averages blocks of 2^`log2_rate` consecutive input samples and emits one averaged sample per block. Both sides use AXI-Stream handshakes, and backpressure is propagated upstream.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: sample width, two's-complement signed.
- `LOG2_MAX_RATE`, default 8: largest supported `log2_rate`. The maximum block length is 2^`LOG2_MAX_RATE`.

Ports:
- `aclk` in, 1: single clock; all logic is rising-edge.
- `aresetn` in, 1: asynchronous, active-low reset.
- `log2_rate` in, 4: decimation exponent. Values above `LOG2_MAX_RATE` are clamped to `LOG2_MAX_RATE`.
- `s_axis_tdata` in, `DATA_WIDTH`: input sample, signed.
- `s_axis_tvalid` in, 1: input sample valid.
- `s_axis_tready` out, 1: block can accept an input sample.
- `m_axis_tdata` out, `DATA_WIDTH`: averaged sample, signed.
- `m_axis_tvalid` out, 1: output holds a sample.
- `m_axis_tready` in, 1: downstream accepts the output.

## Operation
- Accumulator `acc` is signed, `DATA_WIDTH+LOG2_MAX_RATE` bits wide, so it cannot overflow.
- Sample counter `cnt` is `LOG2_MAX_RATE` bits wide.
- Active exponent `rate_q` is a registered copy of the clamped `log2_rate`.
- `rate_q` is updated only when `cnt==0` and no block is in progress. Changing `log2_rate` mid-block therefore takes effect at the next block boundary.
- On an accepted input (`s_axis_tvalid && s_axis_tready`):
  - If `cnt == 2^rate_q - 1`: the output register loads `(acc + sample) >>> rate_q`, truncated to `DATA_WIDTH`. Then `acc` is cleared to 0, `cnt` to 0, and `rate_q` is reloaded.
  - Otherwise: `acc` becomes `acc + sample` and `cnt` becomes `cnt + 1`.
- The shift is arithmetic, so rounding is toward −∞. The result always fits `DATA_WIDTH`; no saturation logic is needed.
- `rate_q==0` gives a registered pass-through of every sample.
- The output register is one deep:
  - `m_axis_tvalid` sets when a result is loaded.
  - It clears on `m_axis_tvalid && m_axis_tready` unless a new result loads in the same cycle, in which case it stays 1 with the new data.
- `s_axis_tready = !m_axis_tvalid || m_axis_tready`. This is combinational, with no combinational path from `s_axis_tvalid` to any output.
- Accumulation only happens on accepted samples, so no input is ever lost or double-counted.
- `m_axis_tdata` holds stable while `m_axis_tvalid && !m_axis_tready`.

## Timing
- Reset values:
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0.
  - `acc` = 0, `cnt` = 0.
  - `rate_q` = 0.
  - `s_axis_tready` = 1, following from `m_axis_tvalid`=0.
- Reset asserted mid-block discards the partial sum and any pending output immediately (asynchronous). After release, the first accepted sample starts a new block.
- Latency: `m_axis_tvalid` rises on the clock edge that accepts the last sample of a block, so the result is visible one cycle after that sample's handshake.
- Throughput: one input per cycle while downstream keeps `m_axis_tready`=1. With `rate_q==0`, this means one output per cycle.
- Full output register with `m_axis_tready`=0: `s_axis_tready`=0, and `acc`/`cnt` hold.
- Simultaneous events:
  - Output drained and a new result loaded in the same cycle: the register takes the new data and `tvalid` stays 1.
  - Rate change on the same edge as block completion: the new `rate_q` applies to the next block.

## Structure
- Shared package `axis_decimator_pkg` contains:
  - `localparam` for the accumulator width `ACC_WIDTH = DATA_WIDTH + LOG2_MAX_RATE`.
  - `function clamp_rate` used for the `log2_rate` clamp.
  - `typedef logic signed [DATA_WIDTH-1:0] sample_t`.
- One sub-module is natural: `axis_output_reg`, the one-deep AXI-Stream output register holding data, valid and the ready generation. Everything else is one `always_ff` with asynchronous `aresetn`.

## Test plan
- `log2_rate`=0, inputs 14, −29, 7, 16 back-to-back with `m_axis_tready`=1 -> outputs 14, −29, 7, 16, each one cycle after input, no gaps.
- `log2_rate`=2, inputs 14, −29, 7, 16 -> one output 2 (sum 8 >>> 2). Then inputs −1, −1, −1, −2 -> output −2 (sum −5 >>> 2, rounded toward −∞).
- `log2_rate`=8, 256 samples of −32768 -> −32768. Then 256 samples of 32767 -> 32767, with no overflow.
- `log2_rate`=1, `m_axis_tready` held 0 after the first output -> `s_axis_tready` drops, `m_axis_tdata` stays stable. On release of `m_axis_tready`, the stalled samples are accepted with none lost and the next average is correct.
- `log2_rate` switched from 2 to 0 after 2 of 4 samples -> the current block still averages 4 samples, and subsequent samples pass through.
- `aresetn` pulsed low after 3 of 4 samples at `log2_rate`=2 -> `m_axis_tvalid`=0 immediately. After release, the next 4 samples 4, 4, 8, 8 -> output 6.
